// File: rtl/if_ctrl_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
package if_ctrl_pkg;

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    FETCH   = 2'd1,
    HALTED  = 2'd2,
    TIMEOUT = 2'd3
  } fetch_state_t;

  localparam logic [1:0] PCSEL_PC4    = 2'b00;
  localparam logic [1:0] PCSEL_JUMP   = 2'b01;
  localparam logic [1:0] PCSEL_BRANCH = 2'b10;

endpackage

// File: rtl/if_mem_watchdog.sv
// Saturating count of consecutive memory-wait cycles; expired marks the last tolerated wait.
module if_mem_watchdog #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expired = (r_cnt == LAST);

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage sequencer: Mealy decode of PC/IF-ID controls around a 4-state FSM.
// Optional perf counters are built when IF_PERF_CNT_EN is defined.
module if_fetch_ctrl
  import if_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        Mem_Ready,
  input  logic        Stall,
  input  logic        Jump,
  input  logic        Branch,
  input  logic        Halt_Req,
  input  logic        Resume,
  output logic [1:0]  PC_Sel,
  output logic        PCWrite,
  output logic        IFIDWrite,
  output logic        IF_Flush,
  output logic        Fetch_Req,
  output logic        Redir_Ack,
  output logic        Fetch_Err,
  output logic [31:0] Stall_Cnt,
  output logic [31:0] Flush_Cnt
);

  fetch_state_t r_state;
  fetch_state_t w_next;
  logic [1:0]   w_pc_sel;
  logic         w_pcwrite, w_ifidwrite, w_flush, w_fetch_req, w_ack;
  logic         w_redir, w_wait, w_expired;

  assign w_redir = Branch | Jump;
  assign w_wait  = (r_state == FETCH) && !Mem_Ready;

  if_mem_watchdog #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_watchdog (
    .CLK       (CLK),
    .RESET     (RESET),
    .i_clr     (!w_wait),
    .i_inc     (w_wait),
    .o_expired (w_expired)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_state <= BOOT;
    else        r_state <= w_next;
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    w_next      = r_state;
    w_pc_sel    = PCSEL_PC4;
    w_pcwrite   = 1'b0;
    w_ifidwrite = 1'b1;
    w_flush     = 1'b1;
    w_fetch_req = 1'b0;
    w_ack       = 1'b0;
    case (r_state)
      BOOT: w_next = FETCH;
      FETCH: begin
        w_fetch_req = 1'b1;
        if (Mem_Ready) begin
          // Redirects outrank Stall: the squashed instruction no longer needs holding.
          if (w_redir) begin
            w_pc_sel  = Branch ? PCSEL_BRANCH : PCSEL_JUMP;
            w_pcwrite = 1'b1;
            w_ack     = 1'b1;
          end else if (Halt_Req) begin
            w_next = HALTED;
          end else if (Stall) begin
            w_ifidwrite = 1'b0;
            w_flush     = 1'b0;
          end else begin
            w_pcwrite = 1'b1;
            w_flush   = 1'b0;
          end
        end else begin
          if (Stall) begin
            w_ifidwrite = 1'b0;
            w_flush     = 1'b0;
          end
          if (w_expired) w_next = TIMEOUT;
        end
      end
      HALTED: begin
        if (w_redir) begin
          w_pc_sel  = Branch ? PCSEL_BRANCH : PCSEL_JUMP;
          w_pcwrite = 1'b1;
          w_ack     = 1'b1;
          w_next    = FETCH;
        end else if (Resume) begin
          w_next = FETCH;
        end
      end
      TIMEOUT: begin
        w_ifidwrite = 1'b0;
        w_flush     = 1'b0;
      end
      default: w_next = BOOT;
    endcase
  end

  assign PC_Sel    = w_pc_sel;
  assign PCWrite   = w_pcwrite;
  assign IFIDWrite = w_ifidwrite;
  assign IF_Flush  = w_flush;
  assign Fetch_Req = w_fetch_req;
  assign Redir_Ack = w_ack;
  assign Fetch_Err = (r_state == TIMEOUT);

`ifdef IF_PERF_CNT_EN
  logic [31:0] r_stall_cnt, r_flush_cnt;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if ((r_state == FETCH) && !w_pcwrite) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_ifidwrite && w_flush)           r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign Stall_Cnt = r_stall_cnt;
  assign Flush_Cnt = r_flush_cnt;
`else
  assign Stall_Cnt = 32'd0;
  assign Flush_Cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl: a driver queues expected controls, a negedge monitor compares.
module tb_if_fetch_ctrl;

  typedef struct packed {
    logic [1:0]  pc_sel;
    logic        pcwrite;
    logic        ifidwrite;
    logic        flush;
    logic        fetch_req;
    logic        ack;
    logic        err;
    logic [31:0] pc;
  } exp_t;

  localparam logic [31:0] JUMP_ADDR = 32'd4;
  localparam logic [31:0] BTB_ADDR  = 32'd16;

  logic        CLK = 1'b0;
  logic        RESET = 1'b0;
  logic        Mem_Ready = 1'b0, Stall = 1'b0, Jump = 1'b0, Branch = 1'b0;
  logic        Halt_Req = 1'b0, Resume = 1'b0;
  logic [1:0]  PC_Sel;
  logic        PCWrite, IFIDWrite, IF_Flush, Fetch_Req, Redir_Ack, Fetch_Err;
  logic [31:0] Stall_Cnt, Flush_Cnt;

  logic [31:0] pc;
  exp_t        exp_q[$];
  int          n_vec = 0;
  int          n_miss = 0;

  if_fetch_ctrl #(.MEM_TIMEOUT(4)) dut (
    .CLK(CLK), .RESET(RESET), .Mem_Ready(Mem_Ready), .Stall(Stall), .Jump(Jump),
    .Branch(Branch), .Halt_Req(Halt_Req), .Resume(Resume), .PC_Sel(PC_Sel),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IF_Flush(IF_Flush), .Fetch_Req(Fetch_Req),
    .Redir_Ack(Redir_Ack), .Fetch_Err(Fetch_Err), .Stall_Cnt(Stall_Cnt), .Flush_Cnt(Flush_Cnt)
  );

  always #5 CLK = ~CLK;

  // Stand-in for the IF datapath PC register and PC_next mux.
  always @(posedge CLK or negedge RESET) begin
    if (!RESET)       pc <= 32'd0;
    else if (PCWrite) pc <= (PC_Sel == 2'b01) ? JUMP_ADDR :
                            (PC_Sel == 2'b10) ? BTB_ADDR  : pc + 32'd4;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [1:0] sel, input logic pw, iw, fl, fr, ack, err,
                              input logic [31:0] p);
    exp_t e;
    e.pc_sel = sel; e.pcwrite = pw; e.ifidwrite = iw; e.flush = fl;
    e.fetch_req = fr; e.ack = ack; e.err = err; e.pc = p;
    return e;
  endfunction

  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("PC_Sel",    {30'd0, PC_Sel}, {30'd0, e.pc_sel});
      check("PCWrite",   {31'd0, PCWrite},   {31'd0, e.pcwrite});
      check("IFIDWrite", {31'd0, IFIDWrite}, {31'd0, e.ifidwrite});
      check("IF_Flush",  {31'd0, IF_Flush},  {31'd0, e.flush});
      check("Fetch_Req", {31'd0, Fetch_Req}, {31'd0, e.fetch_req});
      check("Redir_Ack", {31'd0, Redir_Ack}, {31'd0, e.ack});
      check("Fetch_Err", {31'd0, Fetch_Err}, {31'd0, e.err});
      check("PC",        pc, e.pc);
    end
  end

  task automatic step(input logic rst, rdy, stl, jmp, br, hlt, res, input exp_t e);
    RESET = rst; Mem_Ready = rdy; Stall = stl; Jump = jmp; Branch = br;
    Halt_Req = hlt; Resume = res;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic check_cnt(input string tag, input int stall_exp, input int flush_exp);
`ifdef IF_PERF_CNT_EN
    check({tag, " Stall_Cnt"}, Stall_Cnt, stall_exp);
    check({tag, " Flush_Cnt"}, Flush_Cnt, flush_exp);
`else
    check({tag, " Stall_Cnt"}, Stall_Cnt, 32'd0 & stall_exp);
    check({tag, " Flush_Cnt"}, Flush_Cnt, 32'd0 & flush_exp);
`endif
  endtask

  initial begin
    #20000;
    $display("FAIL global_timeout: simulation did not finish, %0d vectors pending", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge CLK); #1;
    //   rst rdy stl jmp br hlt res      sel   pw iw fl fr ak er pc
    step(0, 1, 0, 0, 0, 0, 0, mk(2'b00, 0, 1, 1, 0, 0, 0, 0));    // held in reset
    check_cnt("reset", 0, 0);
    // Test 1: boot then sequential fetch
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 0, 1, 1, 0, 0, 0, 0));    // BOOT cycle
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 1, 1, 0, 1, 0, 0, 0));
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 1, 1, 0, 1, 0, 0, 4));
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 1, 1, 0, 1, 0, 0, 8));
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 1, 1, 0, 1, 0, 0, 12));
    // Test 2: three wait cycles (one short of timeout) insert bubbles
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 0, 0, 0, 0, mk(2'b00, 0, 1, 1, 1, 0, 0, 16));
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 1, 1, 0, 1, 0, 0, 16));
    check_cnt("test2", 3, 4);
    // Test 3: held jump waits for Mem_Ready, acked once
    step(1, 0, 0, 1, 0, 0, 0, mk(2'b00, 0, 1, 1, 1, 0, 0, 20));
    step(1, 0, 0, 1, 0, 0, 0, mk(2'b00, 0, 1, 1, 1, 0, 0, 20));
    step(1, 1, 0, 1, 0, 0, 0, mk(2'b01, 1, 1, 1, 1, 1, 0, 20));
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 1, 1, 0, 1, 0, 0, 4));
    // Test 4: branch beats jump, both beat stall
    step(1, 1, 1, 1, 1, 0, 0, mk(2'b10, 1, 1, 1, 1, 1, 0, 8));
    step(1, 1, 1, 0, 0, 0, 0, mk(2'b00, 0, 0, 0, 1, 0, 0, 16));   // plain stall holds
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 1, 1, 0, 1, 0, 0, 16));
    // Test 5a: halt then resume at same PC
    step(1, 1, 0, 0, 0, 1, 0, mk(2'b00, 0, 1, 1, 1, 0, 0, 20));
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 0, 1, 1, 0, 0, 0, 20));
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 0, 1, 1, 0, 0, 0, 20));
    step(1, 1, 0, 0, 0, 0, 1, mk(2'b00, 0, 1, 1, 0, 0, 0, 20));
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 1, 1, 0, 1, 0, 0, 20));
    check_cnt("test5", 7, 12);
    // Test 5b: branch in HALTED wins over simultaneous Resume
    step(1, 1, 0, 0, 0, 1, 0, mk(2'b00, 0, 1, 1, 1, 0, 0, 24));
    step(1, 1, 0, 0, 1, 0, 1, mk(2'b10, 1, 1, 1, 0, 1, 0, 24));
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 1, 1, 0, 1, 0, 0, 16));
    // Stall during a memory wait holds IF/ID instead of bubbling
    step(1, 0, 1, 0, 0, 0, 0, mk(2'b00, 0, 0, 0, 1, 0, 0, 20));
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 1, 1, 0, 1, 0, 0, 20));
    // Test 6: four waits reach timeout; redirect ignored there
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 0, 0, 0, 0, mk(2'b00, 0, 1, 1, 1, 0, 0, 24));
    step(1, 1, 0, 1, 0, 0, 0, mk(2'b00, 0, 0, 0, 0, 0, 1, 24));
    step(1, 1, 0, 0, 1, 0, 0, mk(2'b00, 0, 0, 0, 0, 0, 1, 24));
    check_cnt("test6", 13, 18);
    // Reset recovers from TIMEOUT
    step(0, 1, 0, 0, 0, 0, 0, mk(2'b00, 0, 1, 1, 0, 0, 0, 0));
    check_cnt("rearm", 0, 0);
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 0, 1, 1, 0, 0, 0, 0));
    step(1, 1, 0, 0, 0, 0, 0, mk(2'b00, 1, 1, 0, 1, 0, 0, 0));
    @(negedge CLK); #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
